pipe_latch_chain: RTL

//  Parametrised inter-stage pipeline register chain for the hart: DEPTH stages of WIDTH-bit payload, each with a valid bit.

---
 rtl/pipe_latch_chain.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipe_latch_chain.sv
// Parametrised inter-stage pipeline register chain: DEPTH stages of WIDTH-bit payload with
// per-stage stall/flush, back-pressure toward stage 0, and a retire port with counters.
module pipe_latch_chain #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic [WIDTH-1:0]         i_data,
   output logic                     o_ready,
   input  logic [DEPTH-1:0]         i_stall,
   input  logic [DEPTH-1:0]         i_flush,
   output logic [DEPTH-1:0]         o_valid,
   output logic [DEPTH*WIDTH-1:0]   o_data,
   output logic [OCC_W-1:0]         o_occupancy,
   output logic                     o_retire_valid,
   output logic [WIDTH-1:0]         o_retire_data,
   output logic [31:0]              o_retire_count,
   output logic [31:0]              o_bubble_count
);

   localparam int unsigned CNT_W = 32;

   logic             valid_q [DEPTH];
   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] ev;
   logic [DEPTH-1:0] hold;
   logic [CNT_W-1:0] retire_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_q;
   logic [OCC_W-1:0] occ;

   // Pack stage valids and derive flush-masked valids.
   always_comb begin
      valid_vec = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         valid_vec[k] = valid_q[k];
      end
      ev = valid_vec & ~i_flush;
   end

   // Back-pressure ripples from the oldest stage; empty or flushed stages break the chain.
   always_comb begin
      hold            = '0;
      hold[DEPTH-1]   = i_stall[DEPTH-1];
      for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
         hold[k] = i_stall[k] | (ev[k] & hold[k+1]);
      end
   end

   for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
      if (k == 0) begin : g_head
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               valid_q[0] <= 1'b0;
               data_q[0]  <= '0;
            end else if (hold[0]) begin
               valid_q[0] <= ev[0];
            end else begin
               valid_q[0] <= i_valid;
               data_q[0]  <= i_data;
            end
         end
      end else begin : g_body
         // A held upstream stage injects a bubble; a flushed one advances as invalid.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               valid_q[k] <= 1'b0;
               data_q[k]  <= '0;
            end else if (hold[k]) begin
               valid_q[k] <= ev[k];
            end else begin
               valid_q[k] <= ev[k-1] & ~hold[k-1];
               data_q[k]  <= data_q[k-1];
            end
         end
      end
      assign o_data[k*WIDTH +: WIDTH] = data_q[k];
   end

   // Population count of live stages.
   always_comb begin
      occ = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         occ = occ + OCC_W'(valid_q[k]);
      end
   end

   // Retire and bubble counters, free-running and wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         retire_cnt_q <= '0;
         bubble_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_q + {{(CNT_W-1){1'b0}}, o_retire_valid};
         bubble_cnt_q <= bubble_cnt_q + {{(CNT_W-1){1'b0}}, ~o_retire_valid};
      end
   end

   assign o_ready        = ~hold[0];
   assign o_valid        = valid_vec;
   assign o_occupancy    = occ;
   assign o_retire_valid = ev[DEPTH-1] & ~i_stall[DEPTH-1];
   assign o_retire_data  = data_q[DEPTH-1];
   assign o_retire_count = retire_cnt_q;
   assign o_bubble_count = bubble_cnt_q;

endmodule
